// File: rtl/fetch_arb_if.sv
// fetch_arb_if: handshake bundle between NUM_REQ cache controllers, the
// fetch arbiter and the shared line-fetch/writeback engine.
//   req_*  : per-requester fetch_req/cmd/tag/addr in, fetch_gnt/done out
//   eng_*  : single request/cmd/tag/addr toward the engine, gnt/done back
// slave  = arbiter view, master = requesters + engine (testbench) view.
interface fetch_arb_if #(
  parameter int NUM_REQ = 2,
  parameter int TW      = 2,
  parameter int AW      = 32
);
  logic [NUM_REQ-1:0]    req_fetch;
  logic [2*NUM_REQ-1:0]  req_cmd;
  logic [TW*NUM_REQ-1:0] req_tag;
  logic [AW*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_gnt;
  logic [NUM_REQ-1:0]    req_done;
  logic                  eng_req;
  logic [1:0]            eng_cmd;
  logic [TW-1:0]         eng_tag;
  logic [AW-1:0]         eng_addr;
  logic                  eng_gnt;
  logic                  eng_done;

  modport slave (
    input  req_fetch, req_cmd, req_tag, req_addr, eng_gnt, eng_done,
    output req_gnt, req_done, eng_req, eng_cmd, eng_tag, eng_addr
  );

  modport master (
    output req_fetch, req_cmd, req_tag, req_addr, eng_gnt, eng_done,
    input  req_gnt, req_done, eng_req, eng_cmd, eng_tag, eng_addr
  );
endinterface

// File: rtl/fetch_arb.sv
// fetch_arb: round-robin owner of the single line-fetch engine.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   bus          fetch_arb_if.slave (requester and engine handshakes)
//   busy         arbiter not idle
//   err_timeout  sticky watchdog flag, engine did not finish in time
// Flow: IDLE picks a winner scanning from rr_ptr, ISSUE holds eng_req with
// the latched cmd/tag/addr until eng_gnt, WAIT_DONE waits for eng_done and
// then advances rr_ptr past the owner. One fetch outstanding at a time.

// Per-requester decode of the combinational gnt/done strobes.
module fetch_arb_lane #(
  parameter int OW  = 1,
  parameter int IDX = 0
) (
  input  logic [OW-1:0] owner,
  input  logic          in_issue,
  input  logic          in_wait,
  input  logic          eng_gnt,
  input  logic          eng_done,
  output logic          gnt,
  output logic          done
);
  logic hit;
  assign hit  = (owner == OW'(IDX));
  assign gnt  = hit & in_issue & eng_gnt;
  assign done = hit & in_wait & eng_done;
endmodule

module fetch_arb #(
  parameter int addr_width  = 32,
  parameter int list_depth  = 4,
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 1024,
  localparam int TW  = $clog2(list_depth),
  localparam int OW  = $clog2(NUM_REQ),
  localparam int WDW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic         clk,
  input  logic         rst,
  fetch_arb_if.slave   bus,
  output logic         busy,
  output logic         err_timeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_e;

  state_e                state_q, state_d;
  logic [OW-1:0]         rr_q, rr_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [TW-1:0]         tag_q, tag_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [WDW-1:0]        wd_q, wd_d;
  logic                  err_q, err_d;

  // Round-robin search: first requester at or after rr_ptr, wrapping.
  logic          found;
  logic [OW-1:0] win;
  logic [OW:0]   sum;
  logic [OW-1:0] idx;

  always_comb begin
    found = 1'b0;
    win   = rr_q;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_q} + (OW+1)'(k);
      if (sum >= (OW+1)'(NUM_REQ)) sum = sum - (OW+1)'(NUM_REQ);
      idx = sum[OW-1:0];
      if (!found && bus.req_fetch[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cmd_d   = cmd_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          owner_d = win;
          cmd_d   = bus.req_cmd[2*win +: 2];
          tag_d   = bus.req_tag[TW*win +: TW];
          addr_d  = bus.req_addr[addr_width*win +: addr_width];
        end
      end
      // Request stays committed even if the owner drops req_fetch here.
      ISSUE: begin
        if (bus.eng_gnt) begin
          state_d = WAIT_DONE;
          wd_d    = '0;
        end
      end
      WAIT_DONE: begin
        if (bus.eng_done) begin
          state_d = IDLE;
          rr_d    = (owner_q == OW'(NUM_REQ-1)) ? '0 : owner_q + OW'(1);
        end else begin
          // Flag on the TIMEOUT_CYC-th waiting cycle, keep waiting.
          if (wd_q == WDW'(TIMEOUT_CYC-1)) err_d = 1'b1;
          if (wd_q != WDW'(TIMEOUT_CYC))   wd_d  = wd_q + WDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      cmd_q   <= '0;
      tag_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cmd_q   <= cmd_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  logic [NUM_REQ-1:0] gnt_v, done_v;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    fetch_arb_lane #(.OW(OW), .IDX(i)) u_lane (
      .owner    (owner_q),
      .in_issue (state_q == ISSUE),
      .in_wait  (state_q == WAIT_DONE),
      .eng_gnt  (bus.eng_gnt),
      .eng_done (bus.eng_done),
      .gnt      (gnt_v[i]),
      .done     (done_v[i])
    );
  end

  assign bus.req_gnt  = gnt_v;
  assign bus.req_done = done_v;
  assign bus.eng_req  = (state_q == ISSUE);
  assign bus.eng_cmd  = cmd_q;
  assign bus.eng_tag  = tag_q;
  assign bus.eng_addr = addr_q;
  assign busy         = (state_q != IDLE);
  assign err_timeout  = err_q;
endmodule
